// File: rtl/baby_alu_pkg.sv
// Shared definitions for the Baby accumulator/ALU stage.
//   - Op-code constants carried on the 2-bit OP bus.
//   - Default word width and the width of one adder slice (a nibble).
//   - State encoding for the nibble-serial sequencer.
//   - Helper that says which ops need a +1 injected through the carry.
package baby_alu_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;
  localparam int NIBBLE_WIDTH       = 4;

  localparam logic [1:0] OP_LDN   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // LDN and SUB add the one's complement of D; the initial carry of 1
  // completes the two's complement negation.
  function automatic logic op_needs_carry(input logic [1:0] op);
    return (op == OP_LDN) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ttl283_adder.sv
// 4-bit binary full adder slice modelled on the 74x283.
// Ports:
//   a, b  : 4-bit addends
//   c0    : carry in
//   sum   : 4-bit sum
//   c4    : carry out of the top bit
// PROPAGATION_DELAY describes the part's settling time for the timing
// model only; the synthesizable body is purely combinational.
module ttl283_adder #(
  parameter int PROPAGATION_DELAY = 24
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] sum,
  output logic       c4
);

  logic [4:0] full_sum;

  // The delay has no logic to drive; it is kept visible so the
  // integrator sees which clock period the slice was characterised for.
  logic unused_delay;
  assign unused_delay = (PROPAGATION_DELAY > 0);

  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b} + {4'b0000, c0};
    sum      = full_sum[3:0];
    c4       = full_sum[4];
  end

endmodule

// File: rtl/baby_nibble_serial_accumulator.sv
// Accumulator/ALU stage of the Baby datapath, nibble-serial.
// One 4-bit adder slice processes the word least-significant nibble first;
// the carry is held in a flop between nibbles. An op takes NIBBLES clocks
// in RUN, then DONE pulses for one cycle with the final ACC.
// Ports:
//   CLK      : system clock, rising edge
//   RESET    : synchronous active-high reset
//   START    : op request, only honoured in IDLE
//   OP       : 00=LDN (-D), 01=SUB (ACC-D), 10=LOAD (D), 11=CLEAR (0)
//   OPERAND  : store word D, captured on the accepting edge
//   ACC      : accumulator (only meaningful when BUSY=0 or DONE=1)
//   NEGATIVE : ACC sign bit
//   BUSY     : high while sequencing nibbles
//   DONE     : one-cycle pulse when the new result is in ACC
module baby_nibble_serial_accumulator
  import baby_alu_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int ADDER_DELAY = 24
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [1:0]            OP,
  input  logic [WORD_WIDTH-1:0] OPERAND,
  output logic [WORD_WIDTH-1:0] ACC,
  output logic                  NEGATIVE,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int NIBBLES = WORD_WIDTH / NIBBLE_WIDTH;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIBBLE = CNT_W'(NIBBLES - 1);

  state_t                  state_q,   state_d;
  logic [1:0]              op_q,      op_d;
  logic [WORD_WIDTH-1:0]   operand_q, operand_d;
  logic [WORD_WIDTH-1:0]   acc_q,     acc_d;
  logic                    carry_q,   carry_d;
  logic [CNT_W-1:0]        count_q,   count_d;
  logic                    done_q,    done_d;

  logic [NIBBLE_WIDTH-1:0] adder_a;
  logic [NIBBLE_WIDTH-1:0] adder_b;
  logic [NIBBLE_WIDTH-1:0] adder_sum;
  logic                    adder_c4;

  ttl283_adder #(
    .PROPAGATION_DELAY(ADDER_DELAY)
  ) u_adder (
    .a   (adder_a),
    .b   (adder_b),
    .c0  (carry_q),
    .sum (adder_sum),
    .c4  (adder_c4)
  );

  // State register: every flop of the stage, cleared together on reset so
  // an aborted op leaves no partial result behind.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LDN;
      operand_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // Adder operand selection. ACC and the operand both rotate right, so
  // their low nibbles are always the nibble currently being processed.
  always_comb begin
    adder_a = '0;
    adder_b = '0;
    case (op_q)
      OP_SUB: begin
        adder_a = acc_q[NIBBLE_WIDTH-1:0];
        adder_b = ~operand_q[NIBBLE_WIDTH-1:0];
      end
      OP_LDN:  adder_b = ~operand_q[NIBBLE_WIDTH-1:0];
      OP_LOAD: adder_b = operand_q[NIBBLE_WIDTH-1:0];
      default: adder_b = '0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    count_d   = count_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_RUN;
          op_d      = OP;
          operand_d = OPERAND;
          count_d   = '0;
          carry_d   = op_needs_carry(OP);
        end
      end
      ST_RUN: begin
        // After NIBBLES shifts the sum nibbles have walked down into place.
        acc_d     = {adder_sum, acc_q[WORD_WIDTH-1:NIBBLE_WIDTH]};
        operand_d = {{NIBBLE_WIDTH{1'b0}}, operand_q[WORD_WIDTH-1:NIBBLE_WIDTH]};
        carry_d   = adder_c4;
        count_d   = count_q + CNT_W'(1);
        if (count_q == LAST_NIBBLE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    ACC      = acc_q;
    NEGATIVE = acc_q[WORD_WIDTH-1];
    BUSY     = (state_q == ST_RUN);
    DONE     = done_q;
  end

endmodule

// File: tb/tb_baby_nibble_serial_accumulator.sv
`timescale 1ns/1ps
module tb_baby_nibble_serial_accumulator;
  import baby_alu_pkg::*;

  localparam int W       = 32;
  localparam int NIBBLES = W / 4;
  localparam int PERIOD  = 50;
  localparam int NO_OP   = -1000;

  logic         CLK     = 1'b0;
  logic         RESET   = 1'b0;
  logic         START   = 1'b0;
  logic [1:0]   OP      = 2'b00;
  logic [W-1:0] OPERAND = '0;
  logic [W-1:0] ACC;
  logic         NEGATIVE;
  logic         BUSY;
  logic         DONE;

  typedef struct {
    logic [W-1:0] acc;
    int           done_edge;
  } exp_t;

  exp_t         sb[$];
  int           tests_run  = 0;
  int           failures   = 0;
  int           edge_cnt   = 0;
  int           last_start = NO_OP;
  logic [W-1:0] model_acc  = '0;
  bit           mon_en     = 1'b0;

  always #(PERIOD/2) CLK = ~CLK;

  baby_nibble_serial_accumulator #(
    .WORD_WIDTH (W),
    .ADDER_DELAY(24)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .OP      (OP),
    .OPERAND (OPERAND),
    .ACC     (ACC),
    .NEGATIVE(NEGATIVE),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  // Rising-edge index; read #1 after an edge or on the falling edge.
  always @(posedge CLK) edge_cnt++;

  // Reference arithmetic straight from the op definitions.
  function automatic logic [W-1:0] refResult(input logic [1:0] op,
                                             input logic [W-1:0] d,
                                             input logic [W-1:0] acc);
    case (op)
      OP_LDN:  return W'(0) - d;
      OP_SUB:  return acc - d;
      OP_LOAD: return d;
      default: return '0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)",
               name, actual, expected, edge_cnt);
    end
  endtask

  // Present one request for exactly one edge; the model decides whether the
  // stage was free to take it and, if so, queues the expected result.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] d);
    exp_t e;
    @(negedge CLK);
    START   = 1'b1;
    OP      = op;
    OPERAND = d;
    @(posedge CLK);
    #1;
    if (edge_cnt >= last_start + NIBBLES + 1) begin
      model_acc   = refResult(op, d, model_acc);
      last_start  = edge_cnt;
      e.acc       = model_acc;
      e.done_edge = edge_cnt + NIBBLES;
      sb.push_back(e);
    end
    START   = 1'b0;
    OP      = 2'($urandom);
    OPERAND = $urandom;
  endtask

  task automatic applyReset();
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    sb.delete();
    model_acc  = '0;
    last_start = NO_OP;
    @(negedge CLK);
    RESET = 1'b0;
    checkOutput("reset_acc",  ACC, '0);
    checkOutput("reset_neg",  W'(NEGATIVE), '0);
    checkOutput("reset_busy", W'(BUSY), '0);
    checkOutput("reset_done", W'(DONE), '0);
  endtask

  // Advance until the next edge is one where a new op can be accepted.
  task automatic waitFree();
    while (edge_cnt + 1 < last_start + NIBBLES + 1) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic waitUntil(input int target);
    while (edge_cnt < target) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Idle readback of a literal value once the in-flight op has finished.
  task automatic checkIdleAcc(input string name, input logic [W-1:0] expected,
                              input logic expected_neg);
    waitFree();
    @(negedge CLK);
    checkOutput(name, ACC, expected);
    checkOutput({name, "_neg"}, W'(NEGATIVE), W'(expected_neg));
  endtask

  // Monitor: DONE must appear exactly when the scoreboard says, BUSY must
  // match the model's in-flight window, and ACC/NEGATIVE are checked on DONE.
  always @(negedge CLK) begin
    exp_t e;
    bit   exp_done;
    bit   exp_busy;
    if (mon_en) begin
      exp_done = (sb.size() > 0) && (sb[0].done_edge == edge_cnt);
      exp_busy = (edge_cnt >= last_start) && (edge_cnt < last_start + NIBBLES);
      checkOutput("done", W'(DONE), W'(exp_done));
      checkOutput("busy", W'(BUSY), W'(exp_busy));
      if (exp_done) begin
        e = sb.pop_front();
        checkOutput("acc",      ACC, e.acc);
        checkOutput("negative", W'(NEGATIVE), W'(e.acc[W-1]));
      end
    end
  end

  initial begin
    #(PERIOD * 20000);
    $display("[TB] FAIL watchdog: got no completion, expected finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    logic [W-1:0] d;
    logic [1:0]   op;

    applyReset();
    mon_en = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    checkOutput("idle_acc",  ACC, '0);
    checkOutput("idle_neg",  W'(NEGATIVE), '0);
    checkOutput("idle_busy", W'(BUSY), '0);
    checkOutput("idle_done", W'(DONE), '0);

    applyStimulus(OP_LOAD, 32'h1234_5678);
    checkIdleAcc("load", 32'h1234_5678, 1'b0);

    applyStimulus(OP_LDN, 32'h0000_0005);
    waitFree();
    applyStimulus(OP_SUB, 32'hFFFF_FFFF);
    checkIdleAcc("chained_sub", 32'hFFFF_FFFC, 1'b1);

    applyStimulus(OP_LOAD, 32'h8000_0000);
    waitFree();
    applyStimulus(OP_SUB, 32'h0000_0001);
    checkIdleAcc("wrap_sub", 32'h7FFF_FFFF, 1'b0);
    applyStimulus(OP_LDN, 32'h8000_0000);
    checkIdleAcc("ldn_min", 32'h8000_0000, 1'b1);

    applyStimulus(OP_LOAD, 32'hAAAA_AAAA);
    s = last_start;
    waitUntil(s + 3);
    applyStimulus(OP_CLEAR, 32'h0000_0000);
    checkIdleAcc("busy_start_ignored", 32'hAAAA_AAAA, 1'b1);
    applyStimulus(OP_CLEAR, 32'h1234_0000);
    checkIdleAcc("clear", 32'h0000_0000, 1'b0);

    applyStimulus(OP_LOAD, 32'hFFFF_FFFF);
    s = last_start;
    waitUntil(s + 4);
    applyReset();
    applyStimulus(OP_LOAD, 32'h0000_000F);
    checkIdleAcc("load_after_abort", 32'h0000_000F, 1'b0);

    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 4))
        0:       d = 32'h0000_0000;
        1:       d = 32'h0000_0001;
        2:       d = 32'h8000_0000;
        3:       d = 32'hFFFF_FFFF;
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) begin
        applyStimulus(op, d);
        repeat ($urandom_range(0, NIBBLES + 1)) begin
          @(posedge CLK);
          #1;
        end
        applyReset();
      end else begin
        applyStimulus(op, d);
        repeat ($urandom_range(0, 12)) begin
          @(posedge CLK);
          #1;
        end
      end
    end

    waitFree();
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("scoreboard_drained", W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
